// File: rtl/branch_predictor_if.sv
// Fetch-stage lookup and EX-stage resolve signals between the pipeline and the branch predictor.
// No latency of its own; it only bundles wires.
// No backpressure: EX hold is carried on i_stall_E.
interface branch_predictor_if;
    // fetch stage
    logic [31:0] i_pc_F;
    logic        o_pred_taken_F;
    logic [31:0] o_next_pc_F;
    // execute stage
    logic        i_valid_E;
    logic        i_stall_E;
    logic        i_is_br_E;
    logic [31:0] i_pc_E;
    logic        i_taken_E;
    logic [31:0] i_target_E;
    logic        i_pred_taken_E;
    logic [31:0] i_pred_target_E;
    logic        o_mispredict_E;
    logic [31:0] o_redirect_pc_E;
    // debug statistics
    logic [31:0] o_br_count;
    logic [31:0] o_mispred_count;

    // pipeline side
    modport master (
        output i_pc_F, i_valid_E, i_stall_E, i_is_br_E, i_pc_E, i_taken_E,
               i_target_E, i_pred_taken_E, i_pred_target_E,
        input  o_pred_taken_F, o_next_pc_F, o_mispredict_E, o_redirect_pc_E,
               o_br_count, o_mispred_count
    );

    // predictor side
    modport slave (
        input  i_pc_F, i_valid_E, i_stall_E, i_is_br_E, i_pc_E, i_taken_E,
               i_target_E, i_pred_taken_E, i_pred_target_E,
        output o_pred_taken_F, o_next_pc_F, o_mispredict_E, o_redirect_pc_E,
               o_br_count, o_mispred_count
    );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: predicts the fetch PC and resolves control flow in EX.
// Prediction and mispredict/redirect are combinational (0 cycles); table and counters update at the resolve edge.
// An EX stall holds off update, statistics and mispredict until the first non-stalled cycle.
module branch_predictor #(
    parameter int INDEX_W = 6
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    branch_predictor_if.slave    bp
);
    localparam int TAG_W   = 32 - INDEX_W - 2;
    localparam int ENTRIES = 1 << INDEX_W;

    // BTB state
    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];

    logic [31:0] br_count_q;
    logic [31:0] mispred_count_q;

    // fetch lookup
    logic [INDEX_W-1:0] idx_f;
    logic [TAG_W-1:0]   tag_f;
    logic               hit_f;
    logic               pred_taken_f;

    assign idx_f        = bp.i_pc_F[INDEX_W+1:2];
    assign tag_f        = bp.i_pc_F[31:INDEX_W+2];
    assign hit_f        = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
    assign pred_taken_f = hit_f && ctr_q[idx_f][1];

    assign bp.o_pred_taken_F = pred_taken_f;
    assign bp.o_next_pc_F    = pred_taken_f ? target_q[idx_f] : (bp.i_pc_F + 32'd4);

    // execute-stage resolve
    logic [INDEX_W-1:0] idx_e;
    logic [TAG_W-1:0]   tag_e;
    logic               hit_e;
    logic               res;
    logic               br_wrong;
    logic               mispredict;

    assign idx_e = bp.i_pc_E[INDEX_W+1:2];
    assign tag_e = bp.i_pc_E[31:INDEX_W+2];
    assign hit_e = valid_q[idx_e] && (tag_q[idx_e] == tag_e);

    // A held or bubbled EX slot, or a reset cycle, never resolves.
    assign res = bp.i_valid_E && !bp.i_stall_E && !i_rst;

    // Direction wrong, or taken to a different target than the one fetched.
    assign br_wrong = (bp.i_taken_E != bp.i_pred_taken_E) ||
                      (bp.i_taken_E && (bp.i_target_E != bp.i_pred_target_E));

    // A non-branch predicted taken means fetch followed a stale entry.
    assign mispredict = res && (bp.i_is_br_E ? br_wrong : bp.i_pred_taken_E);

    assign bp.o_mispredict_E  = mispredict;
    assign bp.o_redirect_pc_E = bp.i_taken_E ? bp.i_target_E : (bp.i_pc_E + 32'd4);

    assign bp.o_br_count      = br_count_q;
    assign bp.o_mispred_count = mispred_count_q;

    // Byte-offset PC bits never index or tag the table.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{bp.i_pc_F[1:0], bp.i_pc_E[1:0]};

    // next-state for the single entry touched by this resolve
    logic               wr_en;
    logic               valid_d;
    logic [TAG_W-1:0]   tag_d;
    logic [31:0]        target_d;
    logic [1:0]         ctr_d;

    // Compute the new contents of the EX-indexed entry.
    always_comb begin
        wr_en    = 1'b0;
        valid_d  = valid_q[idx_e];
        tag_d    = tag_q[idx_e];
        target_d = target_q[idx_e];
        ctr_d    = ctr_q[idx_e];
        if (res) begin
            if (bp.i_is_br_E) begin
                if (hit_e) begin
                    wr_en = 1'b1;
                    if (bp.i_taken_E) begin
                        ctr_d    = (ctr_q[idx_e] == 2'b11) ? 2'b11 : ctr_q[idx_e] + 2'd1;
                        target_d = bp.i_target_E;
                    end else begin
                        ctr_d    = (ctr_q[idx_e] == 2'b00) ? 2'b00 : ctr_q[idx_e] - 2'd1;
                    end
                end else if (bp.i_taken_E) begin
                    // allocate, evicting whatever alias lived here
                    wr_en    = 1'b1;
                    valid_d  = 1'b1;
                    tag_d    = tag_e;
                    target_d = bp.i_target_E;
                    ctr_d    = 2'b10;
                end
            end else if (hit_e) begin
                wr_en   = 1'b1;
                valid_d = 1'b0;
            end
        end
    end

    // Table write; reset clears every entry and wins over any pending write.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
        end else if (wr_en) begin
            valid_q[idx_e]  <= valid_d;
            tag_q[idx_e]    <= tag_d;
            target_q[idx_e] <= target_d;
            ctr_q[idx_e]    <= ctr_d;
        end
    end

    // Debug statistics; both wrap naturally at 2^32.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            br_count_q      <= '0;
            mispred_count_q <= '0;
        end else begin
            if (res && bp.i_is_br_E) br_count_q <= br_count_q + 32'd1;
            if (mispredict)         mispred_count_q <= mispred_count_q + 32'd1;
        end
    end
endmodule

// File: doc/branch_predictor.md
# branch_predictor

Dynamic branch predictor and redirect controller for the 5-stage RV32I pipeline. It steers the fetch PC from a direct-mapped branch target buffer (BTB) with 2-bit saturating counters. It resolves each control-flow instruction in EX against its prediction, and raises a mispredict/redirect to the hazard logic. It also keeps branch and mispredict statistics for debug.

## Interface
- INDEX_W, 6: BTB index width; 2^INDEX_W entries, indexed by pc[INDEX_W+1:2].
- TAG_W, 32-INDEX_W-2: tag width, compares pc[31:INDEX_W+2].
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst  in  1  reset; one clock, synchronous, active-high.
- i_pc_F  in  32  PC currently in fetch.
- o_pred_taken_F  out  1  fetch-stage prediction; the pipeline carries it to EX.
- o_next_pc_F  out  32  next fetch PC: stored target if predicted taken, else i_pc_F+4.
- i_valid_E  in  1  EX holds a real instruction (not a bubble or flush).
- i_stall_E  in  1  EX held this cycle; blocks update, statistics and mispredict.
- i_is_br_E  in  1  EX instruction is a branch, jal or jalr.
- i_pc_E  in  32  PC of the EX instruction.
- i_taken_E  in  1  resolved direction; 1 for jal/jalr.
- i_target_E  in  32  resolved target address.
- i_pred_taken_E  in  1  prediction carried from fetch.
- i_pred_target_E  in  32  predicted next PC carried from fetch (o_next_pc_F at fetch time).
- o_mispredict_E  out  1  flush IF/ID and ID/EX and redirect fetch.
- o_redirect_pc_E  out  32  correct next PC: i_target_E if taken, else i_pc_E+4.
- o_br_count  out  32  resolved control-flow instructions since reset.
- o_mispred_count  out  32  mispredicts since reset.

## Operation
- Entry state: valid (1), tag (TAG_W), target (32), ctr (2). Encoding is 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Lookup is combinational from registered state. hit = valid[idx] && tag[idx]==i_pc_F[31:INDEX_W+2]. o_pred_taken_F = hit && ctr[idx][1].
- Resolve condition: res = i_valid_E && !i_stall_E && !i_rst.
- Mispredict when res and either of:
  - i_is_br_E and (i_taken_E != i_pred_taken_E, or i_taken_E and i_target_E != i_pred_target_E).
  - !i_is_br_E and i_pred_taken_E (stale entry).
- Update on a clock edge with res, on the entry indexed by i_pc_E:
  - Branch, tag hit: ctr saturating +1 if taken, -1 if not taken (11 stays 11, 00 stays 00). If taken, target <= i_target_E.
  - Branch, miss, taken: allocate or replace. valid=1, tag, target, ctr=10.
  - Branch, miss, not taken: no change.
  - Non-branch with tag hit: valid <= 0.
- Statistics (32-bit, wrap modulo 2^32):
  - o_br_count +1 on res && i_is_br_E.
  - o_mispred_count +1 on o_mispredict_E.
- Address arithmetic is 32-bit unsigned and wraps. 0xFFFFFFFC+4 = 0x00000000.

## Timing
- Reset, applied in one i_rst cycle:
  - All valid bits = 0, all ctr = 01, all targets = 0, both counters = 0.
  - o_mispredict_E = 0 while i_rst is high.
  - o_pred_taken_F = 0 and o_next_pc_F = i_pc_F+4 from the cycle after the reset edge.
- Prediction latency is 0 cycles (combinational, same cycle as i_pc_F).
- Mispredict and redirect are combinational in the EX cycle. The fetch PC loads o_redirect_pc_E at the next edge, and IF/ID and ID/EX clear at the same edge.
- Table writes take effect at the edge ending the resolve cycle. A fetch of the same index in that cycle sees the pre-update state; there is no bypass.
- If EX is stalled for N cycles, the update, count and mispredict happen exactly once, in the first non-stalled cycle.
- Index aliasing: a new tag replaces the old entry; no associativity.
- Reset mid-operation discards any in-flight update on that edge. Reset has priority over every write.

## Test plan
- Reset, then i_pc_F=0x100 -> o_pred_taken_F=0, o_next_pc_F=0x104, both counters 0.
- Taken beq at 0x100 to 0x80, pred 0 -> o_mispredict_E=1, redirect 0x80. Next cycle fetch 0x100 -> pred_taken=1, next_pc=0x80, ctr=10.
- Same branch taken 3 more times, then not taken -> ctr 11, then 10. Prediction stays taken; the not-taken resolve mispredicts with redirect 0x104.
- Not-taken branch at 0x200 with pred 0 -> no mispredict, no allocation. o_br_count +1, o_mispred_count unchanged.
- Alias: an entry exists for 0x100, then taken branch 0x1100→0x40 (same index) -> entry replaced. Fetching 0x100 predicts not taken.
- i_stall_E=1 for 3 cycles with a mispredicted branch -> o_mispredict_E=0 while stalled, asserted in one cycle only. Each counter increments exactly once.
